// File: rtl/panel_io_pkg.sv
// Shared constants for the front-panel I/O bank: LED mode codes and debounce counter sizing.
package panel_io_pkg;

   localparam logic [1:0] LED_OFF  = 2'b00;
   localparam logic [1:0] LED_ON   = 2'b01;
   localparam logic [1:0] LED_SLOW = 2'b10;
   localparam logic [1:0] LED_FAST = 2'b11;

   // Counter must be able to hold DEB_CYCLES-1 for any DEB_CYCLES >= 1.
   function automatic int deb_width(input int cycles);
      return $clog2(cycles + 32'sd1);
   endfunction

   localparam int DEB_CYCLES_DFLT = 32'sd1000;
   localparam int DEB_CW          = deb_width(DEB_CYCLES_DFLT);

endpackage

// File: rtl/panel_debounce.sv
// One button: two-flop synchroniser, polarity fix and stable-count debounce of the level.
module panel_debounce
   import panel_io_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DFLT,
   parameter bit ACT_LOW    = 1'b1
) (
   input  logic ti_clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int            CW       = deb_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 32'sd1);

   logic          meta_r;
   logic          sync_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          pressed_s;
   logic          hit_s;

   // Synchroniser flops reset to the idle pin level so reset release never looks like a press.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_r <= ACT_LOW;
         sync_r <= ACT_LOW;
      end else begin
         meta_r <= btn_raw;
         sync_r <= meta_r;
      end
   end

   assign pressed_s = sync_r ^ ACT_LOW;
   assign hit_s     = (pressed_s != level_r) && (cnt_r == CNT_LAST);

   // Debounce counter and accepted level.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= {CW{1'b0}};
         level_r <= 1'b0;
      end else if (pressed_s == level_r) begin
         cnt_r   <= {CW{1'b0}};
      end else if (hit_s) begin
         cnt_r   <= {CW{1'b0}};
         level_r <= pressed_s;
      end else begin
         cnt_r   <= cnt_r + CW'(32'sd1);
      end
   end

   assign level = level_r;
   // Strobe is high in the cycle whose closing edge raises the level.
   assign rise  = hit_s & pressed_s;

endmodule

// File: rtl/panel_io_bank.sv
// Front-panel I/O bank: debounced buttons with sticky press flags, mode-driven LEDs, add/accumulate.
// Optional PANEL_BLINK_EN builds the blink prescaler; without it blink modes light steadily.
module panel_io_bank
   import panel_io_pkg::*;
#(
   parameter int NBTN        = 32'sd4,
   parameter int NLED        = 32'sd8,
   parameter int W           = 32'sd16,
   parameter int DEB_CYCLES  = 32'sd1000,
   parameter int BLINK_W     = 32'sd24,
   parameter bit BTN_ACT_LOW = 1'b1,
   parameter bit LED_ACT_LOW = 1'b1
) (
   input  logic              ti_clk,
   input  logic              reset_n,
   input  logic [NBTN-1:0]   btn_in,
   input  logic [NBTN-1:0]   btn_clr,
   output logic [NBTN-1:0]   btn_level,
   output logic [NBTN-1:0]   btn_event,
   input  logic [2*NLED-1:0] led_ctrl,
   output logic [NLED-1:0]   led_out,
   input  logic [W-1:0]      op_a,
   input  logic [W-1:0]      op_b,
   input  logic              op_mode,
   input  logic              op_valid,
   output logic [W:0]        sum,
   output logic              sum_valid,
   output logic              sum_ovf
);

   logic [NBTN-1:0] level_s;
   logic [NBTN-1:0] rise_s;
   logic [NBTN-1:0] btn_event_r;
   logic [NLED-1:0] lit_s;
   logic [NLED-1:0] led_r;
   logic            slow_s;
   logic            fast_s;
   logic [W:0]      add_s;
   logic [W+1:0]    acc_s;
   logic [W:0]      sum_r;
   logic            sum_valid_r;
   logic            sum_ovf_r;

   for (genvar g = 0; g < NBTN; g++) begin : g_btn
      panel_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .ACT_LOW    (BTN_ACT_LOW)
      ) u_deb (
         .ti_clk  (ti_clk),
         .reset_n (reset_n),
         .btn_raw (btn_in[g]),
         .level   (level_s[g]),
         .rise    (rise_s[g])
      );
   end

   // Sticky press flags; a rise in the same cycle as a clear keeps the flag set.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_event_r <= {NBTN{1'b0}};
      end else begin
         btn_event_r <= (btn_event_r & ~btn_clr) | rise_s;
      end
   end

`ifdef PANEL_BLINK_EN
   logic [BLINK_W-1:0] blink_cnt_r;

   // Free-running blink prescaler.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_r <= {BLINK_W{1'b0}};
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(32'sd1);
      end
   end

   assign slow_s = blink_cnt_r[BLINK_W-1];
   assign fast_s = blink_cnt_r[BLINK_W-3];
`else
   assign slow_s = 1'b1;
   assign fast_s = 1'b1;
`endif

   // Per-LED lit decode from its 2-bit mode.
   always_comb begin
      lit_s = {NLED{1'b0}};
      for (int i = 0; i < NLED; i++) begin
         case (led_ctrl[2*i +: 2])
            LED_OFF:  lit_s[i] = 1'b0;
            LED_ON:   lit_s[i] = 1'b1;
            LED_SLOW: lit_s[i] = slow_s;
            LED_FAST: lit_s[i] = fast_s;
            default:  lit_s[i] = 1'b0;
         endcase
      end
   end

   // Registered LED pins with polarity applied.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         led_r <= {NLED{LED_ACT_LOW}};
      end else begin
         led_r <= lit_s ^ {NLED{LED_ACT_LOW}};
      end
   end

   assign add_s = {1'b0, op_a} + {1'b0, op_b};
   // Extra top bit captures the carry out of the W+1-bit accumulator.
   assign acc_s = {1'b0, sum_r} + {2'b00, op_a};

   // Add/accumulate result, valid pulse and sticky overflow.
   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_r       <= {(W+1){1'b0}};
         sum_valid_r <= 1'b0;
         sum_ovf_r   <= 1'b0;
      end else begin
         sum_valid_r <= op_valid;
         if (op_valid) begin
            if (!op_mode) begin
               sum_r     <= add_s;
               sum_ovf_r <= 1'b0;
            end else begin
               sum_r     <= acc_s[W:0];
               sum_ovf_r <= sum_ovf_r | acc_s[W+1];
            end
         end
      end
   end

   assign btn_level = level_s;
   assign btn_event = btn_event_r;
   assign led_out   = led_r;
   assign sum       = sum_r;
   assign sum_valid = sum_valid_r;
   assign sum_ovf   = sum_ovf_r;

endmodule

// File: tb/tb_panel_io_bank.sv
// Self-checking bench for panel_io_bank (DEB_CYCLES=4, W=16, BLINK_W=4); honours PANEL_BLINK_EN.
module tb_panel_io_bank;

   logic        ti_clk = 1'b0;
   logic        reset_n;
   logic [3:0]  btn_in;
   logic [3:0]  btn_clr;
   logic [3:0]  btn_level;
   logic [3:0]  btn_event;
   logic [15:0] led_ctrl;
   logic [7:0]  led_out;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_mode;
   logic        op_valid;
   logic [16:0] sum;
   logic        sum_valid;
   logic        sum_ovf;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      logic        mode;
      logic [15:0] a;
      logic [15:0] b;
      logic [16:0] exp_sum;
      logic        exp_ovf;
   } arith_vec_t;

   arith_vec_t tbl [6];

   panel_io_bank #(
      .NBTN        (4),
      .NLED        (8),
      .W           (16),
      .DEB_CYCLES  (4),
      .BLINK_W     (4),
      .BTN_ACT_LOW (1'b1),
      .LED_ACT_LOW (1'b1)
   ) dut (
      .ti_clk    (ti_clk),
      .reset_n   (reset_n),
      .btn_in    (btn_in),
      .btn_clr   (btn_clr),
      .btn_level (btn_level),
      .btn_event (btn_event),
      .led_ctrl  (led_ctrl),
      .led_out   (led_out),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_mode   (op_mode),
      .op_valid  (op_valid),
      .sum       (sum),
      .sum_valid (sum_valid),
      .sum_ovf   (sum_ovf)
   );

   always #5 ti_clk = ~ti_clk;

   // Edges seen since the last reset release; drives the blink reference.
   always @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic step();
      @(posedge ti_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected LED pins after the edge numbered n, from mode rules and prescaler phase.
   function automatic logic [7:0] led_model(input logic [15:0] ctrl, input int n);
      int   ph;
      logic slow, fast;
      logic [7:0] lit;
      ph   = (n - 1) % 16;
      slow = ((ph / 8) % 2) == 1;
      fast = ((ph / 2) % 2) == 1;
`ifndef PANEL_BLINK_EN
      slow = 1'b1;
      fast = 1'b1;
`endif
      for (int i = 0; i < 8; i++) begin
         case ((ctrl >> (2 * i)) & 16'h3)
            16'h0:   lit[i] = 1'b0;
            16'h1:   lit[i] = 1'b1;
            16'h2:   lit[i] = slow;
            default: lit[i] = fast;
         endcase
      end
      return ~lit;
   endfunction

   initial begin
      int   m_sum;
      logic m_ovf;
      logic v;

      tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
      tbl[1] = '{1'b1, 16'hFFFF, 16'h0000, 17'h1FFFF, 1'b0};
      tbl[2] = '{1'b1, 16'hFFFF, 16'h0000, 17'h0FFFE, 1'b1};
      tbl[3] = '{1'b1, 16'h0001, 16'h0000, 17'h0FFFF, 1'b1};
      tbl[4] = '{1'b0, 16'h1234, 16'h4321, 17'h05555, 1'b0};
      tbl[5] = '{1'b1, 16'h0000, 16'h0000, 17'h05555, 1'b0};

      reset_n  = 1'b0;
      btn_in   = 4'hF;
      btn_clr  = 4'h0;
      led_ctrl = 16'h0000;
      op_a     = 16'h0000;
      op_b     = 16'h0000;
      op_mode  = 1'b0;
      op_valid = 1'b0;

      // 1: reset and idle values
      repeat (3) step();
      check("rst_led", led_out, 8'hFF);
      check("rst_sum", sum, 17'h0);
      check("rst_valid", sum_valid, 1'b0);
      reset_n = 1'b1;
      repeat (2) step();
      check("idle_led", led_out, 8'hFF);
      check("idle_sum", sum, 17'h0);
      check("idle_ovf", sum_ovf, 1'b0);
      check("idle_level", btn_level, 4'h0);
      check("idle_event", btn_event, 4'h0);

      // 2: press button 0, level after exactly 2+DEB_CYCLES cycles
      btn_in[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_level_early", btn_level[0], 1'b0);
      end
      step();
      check("t2_level_rise", btn_level[0], 1'b1);
      check("t2_event_set", btn_event[0], 1'b1);
      repeat (4) step();
      btn_in[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_level_held", btn_level[0], 1'b1);
      end
      step();
      check("t2_level_fall", btn_level[0], 1'b0);
      check("t2_event_sticky", btn_event[0], 1'b1);

      // 3: three-cycle glitch on button 1 is rejected
      btn_in[1] = 1'b0;
      repeat (3) step();
      btn_in[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_glitch_level", btn_level[1], 1'b0);
         check("t3_glitch_event", btn_event[1], 1'b0);
      end

      // 4: clear alone, then clear coincident with a rise (set wins), then clear alone
      btn_clr[0] = 1'b1;
      step();
      btn_clr[0] = 1'b0;
      check("t4_clr_alone", btn_event[0], 1'b0);
      btn_in[0] = 1'b0;
      repeat (5) step();
      check("t4_pre_rise", btn_event[0], 1'b0);
      btn_clr[0] = 1'b1;
      step();
      btn_clr[0] = 1'b0;
      check("t4_rise_level", btn_level[0], 1'b1);
      check("t4_set_wins", btn_event[0], 1'b1);
      step();
      check("t4_set_holds", btn_event[0], 1'b1);
      btn_clr[0] = 1'b1;
      step();
      btn_clr[0] = 1'b0;
      check("t4_clr_later", btn_event[0], 1'b0);
      btn_in[0] = 1'b1;
      repeat (8) step();
      check("t4_release_level", btn_level[0], 1'b0);
      check("t4_release_noset", btn_event[0], 1'b0);

      // 5: table of back-to-back arithmetic operations
      for (int i = 0; i < 6; i++) begin
         op_mode  = tbl[i].mode;
         op_a     = tbl[i].a;
         op_b     = tbl[i].b;
         op_valid = 1'b1;
         step();
         check("t5_sum", sum, tbl[i].exp_sum);
         check("t5_ovf", sum_ovf, tbl[i].exp_ovf);
         check("t5_valid", sum_valid, 1'b1);
      end
      op_valid = 1'b0;
      step();
      check("t5_valid_drop", sum_valid, 1'b0);
      check("t5_sum_hold", sum, 17'h05555);

      // randomized arithmetic against an integer model
      m_sum = 32'h5555;
      m_ovf = 1'b0;
      for (int i = 0; i < 60; i++) begin
         v        = ($urandom_range(3, 0) != 0);
         op_mode  = $urandom_range(1, 0);
         op_a     = 16'($urandom);
         op_b     = 16'($urandom);
         if (($urandom_range(3, 0) == 0) && op_mode) op_a = 16'hFFFF;
         op_valid = v;
         step();
         if (v) begin
            if (!op_mode) begin
               m_sum = int'(op_a) + int'(op_b);
               m_ovf = 1'b0;
            end else begin
               m_sum = m_sum + int'(op_a);
               if (m_sum >= 131072) begin
                  m_sum = m_sum - 131072;
                  m_ovf = 1'b1;
               end
            end
         end
         check("rnd_sum", sum, 32'(m_sum));
         check("rnd_ovf", sum_ovf, m_ovf);
         check("rnd_valid", sum_valid, v);
      end
      op_valid = 1'b0;

      // 6: fast blink on LED 0
      led_ctrl = 16'h0003;
      for (int i = 0; i < 8; i++) begin
         step();
         check("t6_fast_led", led_out, led_model(16'h0003, cyc));
      end
      for (int i = 0; i < 40; i++) begin
         led_ctrl = 16'($urandom);
         step();
         check("rnd_led", led_out, led_model(led_ctrl, cyc));
      end
      led_ctrl = 16'h5555;
      step();
      check("led_all_on", led_out, 8'h00);

      // reset in the middle of an operation discards it
      op_mode  = 1'b0;
      op_a     = 16'hFFFF;
      op_b     = 16'hFFFF;
      op_valid = 1'b1;
      step();
      op_mode  = 1'b1;
      step();
      check("pre_rst_ovf", sum_ovf, 1'b1);
      btn_in[3] = 1'b0;
      repeat (7) step();
      check("pre_rst_event", btn_event[3], 1'b1);
      op_mode  = 1'b0;
      op_a     = 16'h0005;
      op_b     = 16'h0005;
      op_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_sum_async", sum, 17'h0);
      step();
      check("mid_rst_sum", sum, 17'h0);
      check("mid_rst_valid", sum_valid, 1'b0);
      check("mid_rst_ovf", sum_ovf, 1'b0);
      check("mid_rst_led", led_out, 8'hFF);
      check("mid_rst_event", btn_event, 4'h0);
      check("mid_rst_level", btn_level, 4'h0);
      op_valid = 1'b0;
      btn_in   = 4'hF;
      reset_n  = 1'b1;
      step();
      check("post_rst_valid", sum_valid, 1'b0);
      check("post_rst_sum", sum, 17'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
